custom_ptr_sync_wr: RTL and testbench
=====================================

// Module: custom_ptr_sync_wr
// PURPOSE
//  Parametrised successor to the fixed 2-flop read-pointer synchroniser on the write side of the async FIFO.
//  - Brings the read-domain Gray pointer into wclk_i through SYNC_STAGES flops.
//  - Converts it to binary and computes free space, full and almost-full against the local write pointer.
//  - Flags illegal Gray steps (more than 1 bit changed) as a CDC health monitor.
// PARAMETERS
//  ADDRSIZE     4  FIFO address bits; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits
//  SYNC_STAGES  2  synchroniser flop count; legal 2..4 (elaboration error otherwise)
//  AFULL_THRESH 2  walmost_full_o asserts when wfree_o <= AFULL_THRESH; legal 0..2**ADDRSIZE
//  ERR_CNT_W    8  width of the Gray-error counter
// PORTS
//  wclk_i           in   1            write-domain clock
//  wrst_n_i         in   1            reset, asynchronous assert, active-low
//  rptr_g           in   ADDRSIZE+1   read pointer, Gray, from rclk domain (async)
//  wptr_bin_i       in   ADDRSIZE+1   local write pointer, binary, wclk domain
//  err_clr_i        in   1            clears gray_err_o and gray_err_cnt_o
//  rptr_sync_g      out  ADDRSIZE+1   synchronised Gray read pointer (last sync stage)
//  rptr_sync_bin    out  ADDRSIZE+1   registered binary of rptr_sync_g
//  rptr_adv_o       out  1            1-cycle pulse when rptr_sync_bin changes
//  wfree_o          out  ADDRSIZE+1   free entries, 0..2**ADDRSIZE
//  wfull_o          out  1            FIFO full (or pointer overrun)
//  walmost_full_o   out  1            wfree_o <= AFULL_THRESH
//  gray_err_o       out  1            sticky: illegal Gray step seen
//  gray_err_cnt_o   out  ERR_CNT_W    saturating count of illegal steps
// BEHAVIOUR
//  Reset
//  - wrst_n_i low clears every flop to 0 immediately, independent of the clock.
//  - Resulting outputs: rptr_sync_g=0, rptr_sync_bin=0, rptr_adv_o=0, gray_err_o=0, gray_err_cnt_o=0.
//  - wfree_o/wfull_o follow wptr_bin_i (see Occupancy).
//  - Reset mid-operation discards all in-flight sync stages; no pulse is produced on exit from reset.
//  Sync chain
//  - stage[0] <= rptr_g; stage[k] <= stage[k-1]; rptr_sync_g = stage[SYNC_STAGES-1].
//  - No logic between rptr_g and stage[0].
//  Binary
//  - rptr_sync_bin <= gray2bin(rptr_sync_g); gray2bin is the MSB-down XOR prefix.
//  - Latency from an rptr_g change: SYNC_STAGES edges to rptr_sync_g, SYNC_STAGES+1 edges to rptr_sync_bin.
//  Advance pulse
//  - rptr_adv_o <= (gray2bin(rptr_sync_g) != rptr_sync_bin), so it is high in the cycle the new binary value appears.
//  - Back-to-back steps give consecutive pulses.
//  Gray check
//  - Evaluated on the same edge as the rptr_sync_bin update.
//  - If popcount(rptr_sync_g ^ prev_sync_g) > 1, where prev_sync_g is the value rptr_sync_bin was derived from:
//    - gray_err_o <= 1.
//    - gray_err_cnt_o increments, saturating at all-ones.
//  - err_clr_i=1 clears both. If an error is detected on the same edge as the clear, the error wins: gray_err_o=1, gray_err_cnt_o=1.
//  Occupancy (combinational from wptr_bin_i and the registered rptr_sync_bin)
//  - used = (wptr_bin_i - rptr_sync_bin) mod 2**(ADDRSIZE+1).
//  - used <= 2**ADDRSIZE: wfree_o = 2**ADDRSIZE - used; wfull_o = (used == 2**ADDRSIZE).
//  - used > 2**ADDRSIZE (overrun, illegal): wfree_o = 0, wfull_o = 1.
//  - walmost_full_o = (wfree_o <= AFULL_THRESH).
//  - Pointer wrap is handled by the modulo arithmetic; the MSB acts as the lap bit.
//  - Full is pessimistic: a read is seen SYNC_STAGES+1 cycles late, never early.
// TESTING (ADDRSIZE=4, SYNC_STAGES=2, AFULL_THRESH=2 unless stated)
//  1. Reset with wptr_bin_i=0, rptr_g=0:
//     -> all sync outputs 0, wfree_o=16, wfull_o=0, walmost_full_o=0, gray_err_o=0.
//  2. rptr_g steps 0->1->3->2, one per clock, starting at edge N:
//     -> rptr_sync_g shows 1,3,2 at edges N+2..N+4.
//     -> rptr_sync_bin shows 1,2,3 at edges N+3..N+5, with rptr_adv_o high for exactly those 3 cycles.
//  3. wptr_bin_i=16, rptr_g=0:
//     -> wfull_o=1, wfree_o=0, walmost_full_o=1.
//     Then rptr_g=1 -> wfull_o drops after exactly 3 edges; wfree_o=1, walmost_full_o=1.
//  4. Wrap: rptr at binary 30 (rptr_g=5'b10001), wptr_bin_i=3:
//     -> wfree_o=11, wfull_o=0.
//     Then wptr_bin_i=14 -> wfree_o=0, wfull_o=1.
//  5. rptr_g 0->5'b00011 in one step:
//     -> gray_err_o=1, gray_err_cnt_o=1.
//     Another 2-bit step with err_clr_i=1 on the detecting edge -> cnt=1.
//     Force 300 errors with ERR_CNT_W=8 -> cnt saturates at 255.
//  6. Assert wrst_n_i mid-stream between clock edges:
//     -> outputs clear before the next edge; no rptr_adv_o pulse after release.
//     SYNC_STAGES=4 rerun of test 2 -> latency 4/5 edges.

Source files
------------

// File: rtl/custom_ptr_sync_wr.sv
// custom_ptr_sync_wr: read-pointer synchroniser for the async FIFO write side,
// with free-space/full/almost-full flags and a Gray-step CDC health monitor.
`default_nettype none

module custom_ptr_sync_wr #(
  parameter int ADDRSIZE     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 2,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 wclk_i,
  input  logic                 wrst_n_i,
  input  logic [ADDRSIZE:0]    rptr_g,
  input  logic [ADDRSIZE:0]    wptr_bin_i,
  input  logic                 err_clr_i,
  output logic [ADDRSIZE:0]    rptr_sync_g,
  output logic [ADDRSIZE:0]    rptr_sync_bin,
  output logic                 rptr_adv_o,
  output logic [ADDRSIZE:0]    wfree_o,
  output logic                 wfull_o,
  output logic                 walmost_full_o,
  output logic                 gray_err_o,
  output logic [ERR_CNT_W-1:0] gray_err_cnt_o
);

  localparam logic [ADDRSIZE:0] c_depth  = (ADDRSIZE+1)'(1 << ADDRSIZE);
  localparam logic [ADDRSIZE:0] c_thresh = (ADDRSIZE+1)'(AFULL_THRESH);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("custom_ptr_sync_wr: SYNC_STAGES must be 2..4");
  end
  if (AFULL_THRESH < 0 || AFULL_THRESH > (1 << ADDRSIZE)) begin : g_bad_thresh
    $error("custom_ptr_sync_wr: AFULL_THRESH must be 0..2**ADDRSIZE");
  end

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0]    sync_q [SYNC_STAGES];
  logic [ADDRSIZE:0]    bin_q, bin_d;
  logic                 adv_q, adv_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDRSIZE:0]    prev_g;
  logic                 step_bad;
  logic [ADDRSIZE:0]    used;

  // Raw capture into stage 0: no logic may sit in front of the first flop.
  for (genvar k = 0; k < SYNC_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) sync_q[k] <= '0;
        else           sync_q[k] <= rptr_g;
      end
    end else begin : g_rest
      always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) sync_q[k] <= '0;
        else           sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign rptr_sync_g = sync_q[SYNC_STAGES-1];

  // bin_q was derived from the previous synced Gray value, so re-encoding it recovers that value.
  always_comb begin
    prev_g   = bin_q ^ (bin_q >> 1);
    step_bad = ($countones(rptr_sync_g ^ prev_g) > 1);
    bin_d    = gray2bin(rptr_sync_g);
    adv_d    = (bin_d != bin_q);
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (step_bad) begin
      err_d = 1'b1;
      if (err_clr_i)       cnt_d = ERR_CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      bin_q <= '0;
      adv_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      adv_q <= adv_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign rptr_sync_bin  = bin_q;
  assign rptr_adv_o     = adv_q;
  assign gray_err_o     = err_q;
  assign gray_err_cnt_o = cnt_q;

  // Modulo subtraction handles the lap bit; anything above depth is an overrun.
  always_comb begin
    used    = wptr_bin_i - bin_q;
    wfree_o = '0;
    wfull_o = 1'b1;
    if (used <= c_depth) begin
      wfree_o = c_depth - used;
      wfull_o = (used == c_depth);
    end
  end

  assign walmost_full_o = (wfree_o <= c_thresh);

endmodule

`default_nettype wire

// File: tb/tb_custom_ptr_sync_wr.sv
// Self-checking bench for custom_ptr_sync_wr: vector table plus directed corner sequences.
`default_nettype none

module tb_custom_ptr_sync_wr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rg, wp;
  logic       clr;

  logic [4:0] sg, sb, free;
  logic       adv, full, af, err;
  logic [7:0] cnt;
  logic [4:0] sg4, sb4, free4;
  logic       adv4, full4, af4, err4;
  logic [7:0] cnt4;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  custom_ptr_sync_wr #(.ADDRSIZE(4), .SYNC_STAGES(2), .AFULL_THRESH(2), .ERR_CNT_W(8)) dut (
    .wclk_i(clk), .wrst_n_i(rst_n), .rptr_g(rg), .wptr_bin_i(wp), .err_clr_i(clr),
    .rptr_sync_g(sg), .rptr_sync_bin(sb), .rptr_adv_o(adv), .wfree_o(free),
    .wfull_o(full), .walmost_full_o(af), .gray_err_o(err), .gray_err_cnt_o(cnt)
  );

  custom_ptr_sync_wr #(.ADDRSIZE(4), .SYNC_STAGES(4), .AFULL_THRESH(2), .ERR_CNT_W(8)) dut4 (
    .wclk_i(clk), .wrst_n_i(rst_n), .rptr_g(rg), .wptr_bin_i(wp), .err_clr_i(clr),
    .rptr_sync_g(sg4), .rptr_sync_bin(sb4), .rptr_adv_o(adv4), .wfree_o(free4),
    .wfull_o(full4), .walmost_full_o(af4), .gray_err_o(err4), .gray_err_cnt_o(cnt4)
  );

  typedef struct {
    logic [4:0] rg;
    logic [4:0] wp;
    logic [4:0] e_sg;
    logic [4:0] e_sb;
    logic       e_adv;
    logic [4:0] e_free;
    logic       e_full;
    logic       e_af;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge, are captured on the next rising edge, checked at the following fall.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rg    = '0;
    wp    = '0;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          rg      wp     sg     sb     adv  free   full af
    vt[0] = '{5'd0, 5'd8, 5'd0, 5'd0, 1'b0, 5'd8,  1'b0, 1'b0};
    vt[1] = '{5'd1, 5'd8, 5'd0, 5'd0, 1'b0, 5'd8,  1'b0, 1'b0};
    vt[2] = '{5'd3, 5'd8, 5'd1, 5'd0, 1'b0, 5'd8,  1'b0, 1'b0};
    vt[3] = '{5'd2, 5'd8, 5'd3, 5'd1, 1'b1, 5'd9,  1'b0, 1'b0};
    vt[4] = '{5'd2, 5'd8, 5'd2, 5'd2, 1'b1, 5'd10, 1'b0, 1'b0};
    vt[5] = '{5'd2, 5'd8, 5'd2, 5'd3, 1'b1, 5'd11, 1'b0, 1'b0};
    vt[6] = '{5'd2, 5'd8, 5'd2, 5'd3, 1'b0, 5'd11, 1'b0, 1'b0};

    rst_n = 1'b1;
    do_reset();

    // Reset state with both pointers at zero
    chk("rst_sg", 32'(sg), 0);
    chk("rst_sb", 32'(sb), 0);
    chk("rst_adv", 32'(adv), 0);
    chk("rst_free", 32'(free), 16);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(af), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(cnt), 0);

    // Gray walk 0->1->3->2 through the table
    for (int i = 0; i < 7; i++) begin
      rg = vt[i].rg;
      wp = vt[i].wp;
      step();
      chk($sformatf("vec%0d_sg", i),   32'(sg),   32'(vt[i].e_sg));
      chk($sformatf("vec%0d_sb", i),   32'(sb),   32'(vt[i].e_sb));
      chk($sformatf("vec%0d_adv", i),  32'(adv),  32'(vt[i].e_adv));
      chk($sformatf("vec%0d_free", i), 32'(free), 32'(vt[i].e_free));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].e_full));
      chk($sformatf("vec%0d_af", i),   32'(af),   32'(vt[i].e_af));
      chk($sformatf("vec%0d_err", i),  32'(err),  0);
    end

    // Full, then a read releases it exactly three edges later
    do_reset();
    wp = 5'd16;
    #1;
    chk("full_full", 32'(full), 1);
    chk("full_free", 32'(free), 0);
    chk("full_af", 32'(af), 1);
    rg = 5'd1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("rel_e%0d_full", k), 32'(full), (k == 3) ? 0 : 1);
    end
    chk("rel_free", 32'(free), 1);
    chk("rel_af", 32'(af), 1);

    // Wrap: read pointer at binary 30
    do_reset();
    rg = 5'b10001;
    wp = 5'd3;
    repeat (3) step();
    chk("wrap_sb", 32'(sb), 30);
    chk("wrap_free", 32'(free), 11);
    chk("wrap_full", 32'(full), 0);
    wp = 5'd14;
    #1;
    chk("wrap2_free", 32'(free), 0);
    chk("wrap2_full", 32'(full), 1);

    // Illegal two-bit step, detected on the edge that updates the binary
    do_reset();
    rg = 5'b00011;
    repeat (2) step();
    chk("gerr_early", 32'(err), 0);
    step();
    chk("gerr_flag", 32'(err), 1);
    chk("gerr_cnt", 32'(cnt), 1);
    rg = 5'b00110;
    repeat (2) step();
    chk("gerr_pre_cnt", 32'(cnt), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("gerr_clrwin_flag", 32'(err), 1);
    chk("gerr_clrwin_cnt", 32'(cnt), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("gerr_clr_flag", 32'(err), 0);
    chk("gerr_clr_cnt", 32'(cnt), 0);

    // Saturation: alternating 0/3 errors on every edge from the third onward
    do_reset();
    for (int k = 1; k <= 302; k++) begin
      rg = (k % 2 == 1 && k <= 300) ? 5'd3 : 5'd0;
      step();
      if (k == 100 || k == 256 || k == 257 || k == 258 || k == 302)
        chk($sformatf("sat_e%0d_cnt", k), 32'(cnt), (k - 2 > 255) ? 255 : k - 2);
    end
    chk("sat_flag", 32'(err), 1);

    // Asynchronous reset between edges
    do_reset();
    rg = 5'd1;
    wp = 5'd8;
    repeat (2) step();
    @(posedge clk);
    #2;
    chk("arst_pre_sb", 32'(sb), 1);
    chk("arst_pre_adv", 32'(adv), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_sg", 32'(sg), 0);
    chk("arst_sb", 32'(sb), 0);
    chk("arst_adv", 32'(adv), 0);
    rg = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("arst_post_e%0d_adv", k), 32'(adv), 0);
    end

    // Four-stage latency: Gray after 4 edges, binary and pulse after 5
    do_reset();
    rg = 5'd1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("s4_e%0d_sg", k), 32'(sg4), (k >= 4) ? 1 : 0);
      chk($sformatf("s4_e%0d_sb", k), 32'(sb4), (k >= 5) ? 1 : 0);
      chk($sformatf("s4_e%0d_adv", k), 32'(adv4), (k == 5) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
